// File: rtl/mat_neg_transpose_stream.sv
// Negate-and-transpose sequencer: loads an MxN float32 matrix row-major and
// streams the NxM result (sign-flipped, transposed) row-major.
module mat_neg_transpose_stream #(
    parameter int unsigned M = 1,
    parameter int unsigned N = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        frame_err
);

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = M * N;
    localparam int unsigned RW    = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_LOAD  = 1'b0,
        S_DRAIN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [RW-1:0]    ri_q, ri_d;
    logic [CW-1:0]    ci_q, ci_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             frame_err_q, frame_err_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic [DW-1:0]    mem_q [DEPTH];

    logic             in_fire;
    logic             out_fire;
    logic             ri_last;
    logic             ci_last;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [DW-1:0]    rd_word;

    function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return AW'(r) * AW'(N) + AW'(c);
    endfunction

    assign in_fire  = in_valid & in_ready_q & (state_q == S_LOAD);
    assign out_fire = out_valid_q & out_ready & (state_q == S_DRAIN);
    assign ri_last  = (ri_q == RW'(M - 1));
    assign ci_last  = (ci_q == CW'(N - 1));
    assign wr_en    = in_fire;
    assign wr_addr  = addr_of(ri_q, ci_q);
    assign rd_addr  = addr_of(ri_d, ci_d);
    // Bypass covers the 1x1 case where the element being written is the first one read.
    assign rd_word  = (wr_en && (wr_addr == rd_addr)) ? in_data : mem_q[rd_addr];

    // Next-state, counters and registered-output prefetch
    always_comb begin
        state_d     = state_q;
        ri_d        = ri_q;
        ci_d        = ci_q;
        frame_err_d = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (in_fire) begin
                    if (ri_last && ci_last) begin
                        ri_d = '0;
                        ci_d = '0;
                        if (in_last) begin
                            state_d = S_DRAIN;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else if (in_last) begin
                        ri_d        = '0;
                        ci_d        = '0;
                        frame_err_d = 1'b1;
                    end else if (ci_last) begin
                        ci_d = '0;
                        ri_d = ri_q + RW'(1);
                    end else begin
                        ci_d = ci_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (out_fire) begin
                    if (ri_last) begin
                        ri_d = '0;
                        if (ci_last) begin
                            ci_d    = '0;
                            state_d = S_LOAD;
                        end else begin
                            ci_d = ci_q + CW'(1);
                        end
                    end else begin
                        ri_d = ri_q + RW'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase

        in_ready_d  = (state_d == S_LOAD);
        out_valid_d = (state_d == S_DRAIN);
        out_last_d  = (state_d == S_DRAIN) && (ri_d == RW'(M - 1)) && (ci_d == CW'(N - 1));
        out_data_d  = out_data_q;
        if (state_d == S_DRAIN) begin
            out_data_d = {~rd_word[DW-1], rd_word[DW-2:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            ri_q        <= '0;
            ci_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ri_q        <= ri_d;
            ci_q        <= ci_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
            out_data_q  <= out_data_d;
        end
    end

    // Frame buffer, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mat_neg_transpose_stream.sv
// Directed bench: a 2x3 instance for streaming, framing, reset and backpressure,
// and a 1x1 instance for special float values.
module tb_mat_neg_transpose_stream;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last, frame_err;
    logic [31:0] in_data, out_data;

    logic        in_valid1, in_ready1, in_last1, out_valid1, out_ready1, out_last1, frame_err1;
    logic [31:0] in_data1, out_data1;

    int errors = 0;
    int checks = 0;

    logic [31:0] fr_in  [2][6];
    logic [31:0] fr_out [2][6];

    mat_neg_transpose_stream #(.M(2), .N(3)) u_dut23 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .frame_err(frame_err)
    );

    mat_neg_transpose_stream #(.M(1), .N(1)) u_dut11 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_last(in_last1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_last(out_last1),
        .frame_err(frame_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic push(input logic [31:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("push_timeout", 32'(t), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pop(input logic [31:0] ed, input logic el, input int stall);
        int t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("in_ready_drain", 32'(in_ready), 32'd0);
        chk("out_data", out_data, ed);
        chk("out_last", 32'(out_last), 32'(el));
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", out_data, ed);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic load_frame(input int f);
        for (int k = 0; k < 6; k++) begin
            push(fr_in[f][k], k == 5);
            if (k < 5) chk("no_early_valid", 32'(out_valid), 32'd0);
        end
        chk("valid_after_last_in", 32'(out_valid), 32'd1);
        chk("in_ready_low_drain", 32'(in_ready), 32'd0);
    endtask

    task automatic drain_frame(input int f, input int max_stall);
        for (int k = 0; k < 6; k++) begin
            pop(fr_out[f][k], k == 5, (max_stall > 0) ? $urandom_range(0, max_stall) : 0);
        end
        chk("in_ready_after_last_out", 32'(in_ready), 32'd1);
        chk("valid_low_after_last_out", 32'(out_valid), 32'd0);
    endtask

    task automatic one_by_one(input logic [31:0] d, input logic [31:0] e);
        int t = 0;
        in_valid1 = 1'b1;
        in_data1  = d;
        in_last1  = 1'b1;
        while (!in_ready1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        in_valid1 = 1'b0;
        in_last1  = 1'b0;
        chk("s_valid", 32'(out_valid1), 32'd1);
        chk("s_data", out_data1, e);
        chk("s_last", 32'(out_last1), 32'd1);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        chk("s_valid_drop", 32'(out_valid1), 32'd0);
        chk("s_in_ready", 32'(in_ready1), 32'd1);
    endtask

    initial begin
        fr_in[0]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        fr_out[0] = '{32'hBF800000, 32'hC0800000, 32'hC0000000, 32'hC0A00000, 32'hC0400000, 32'hC0C00000};
        fr_in[1]  = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005, 32'h00000006};
        fr_out[1] = '{32'h80000001, 32'h80000004, 32'h80000002, 32'h80000005, 32'h80000003, 32'h80000006};

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; in_last1 = 1'b0; out_ready1 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_in_ready_11", 32'(in_ready1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Basic 2x3 frame, no stalls
        load_frame(0);
        drain_frame(0, 0);

        // Special values through the 1x1 instance
        one_by_one(32'h00000000, 32'h80000000);
        one_by_one(32'hFF800000, 32'h7F800000);
        one_by_one(32'h7FC00001, 32'hFFC00001);

        // Random backpressure
        load_frame(0);
        drain_frame(0, 3);

        // Early in_last on third element
        push(fr_in[0][0], 1'b0);
        push(fr_in[0][1], 1'b0);
        push(fr_in[0][2], 1'b1);
        chk("early_err_pulse", 32'(frame_err), 32'd1);
        chk("early_err_no_out", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("early_err_single", 32'(frame_err), 32'd0);
        load_frame(1);
        drain_frame(1, 0);

        // Sixth element without in_last
        for (int k = 0; k < 6; k++) push(fr_in[0][k], 1'b0);
        chk("late_err_pulse", 32'(frame_err), 32'd1);
        chk("late_err_no_out", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("late_err_single", 32'(frame_err), 32'd0);
        chk("late_err_no_out2", 32'(out_valid), 32'd0);
        chk("late_err_in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a drain
        load_frame(0);
        pop(fr_out[0][0], 1'b0, 0);
        pop(fr_out[0][1], 1'b0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready_up", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_no_residual", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        load_frame(1);
        drain_frame(1, 1);

        // Back-to-back frames with in_valid held high during drain
        load_frame(0);
        in_valid = 1'b1;
        in_data  = fr_in[1][0];
        in_last  = 1'b0;
        drain_frame(0, 1);
        chk("b2b_in_valid_held", 32'(in_valid), 32'd1);
        load_frame(1);
        drain_frame(1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
